// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the regfile write port among N_REQ writeback sources.
// It also keeps a pending-write scoreboard that issue uses to stall on RAW and WAW hazards.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [N_REQ*5-1:0]    i_req_rd,
  input  logic [N_REQ*XLEN-1:0] i_req_data,
  output logic                  o_rf_we,
  output logic [4:0]            o_rf_rd_addr,
  output logic [XLEN-1:0]       o_rf_rd_data,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  input  logic [4:0]            i_rs1_addr,
  input  logic [4:0]            i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rd_busy,
  output logic                  o_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    win_s;
  logic             found_s;
  int               idx_s;
  logic [N_REQ-1:0] grant_s;
  logic             hs_s;
  logic [4:0]       sel_rd_s;
  logic [XLEN-1:0]  sel_data_s;
  logic             set_s;
  logic             orphan_s;
  logic             we_r;
  logic [4:0]       addr_r;
  logic [XLEN-1:0]  data_r;
  logic [31:0]      pending_r;
  logic [31:0]      pending_nxt_s;
  logic             err_r;
  logic             err_nxt_s;

  // A register being committed this cycle is forwarded by the regfile, so it is not busy.
  function automatic logic busy_f(input logic [4:0] a, input logic [31:0] pend,
                                  input logic we, input logic [4:0] wa);
    return (a != 5'd0) && pend[a] && !(we && (wa == a));
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s   = (int'(ptr_r) + i) % N_REQ;
      win_s   = (!found_s && i_req_valid[idx_s]) ? PW'(idx_s) : win_s;
      found_s = found_s | i_req_valid[idx_s];
    end
  end

  // Grant vector and the winning request's payload.
  always_comb begin
    grant_s    = found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_s) : '0;
    hs_s       = found_s & i_rst_n;
    sel_rd_s   = i_req_rd[int'(win_s)*5 +: 5];
    sel_data_s = i_req_data[int'(win_s)*XLEN +: XLEN];
  end

  assign o_req_ready = grant_s & {N_REQ{i_rst_n}};

  // Scoreboard update: clear on commit first, then set on issue so a collision leaves the bit set.
  always_comb begin
    set_s         = i_issue_valid && (i_issue_rd != 5'd0);
    pending_nxt_s = pending_r & ~(we_r ? (32'd1 << addr_r) : 32'd0);
    pending_nxt_s = pending_nxt_s | (set_s ? (32'd1 << i_issue_rd) : 32'd0);
    pending_nxt_s[0] = 1'b0;
    orphan_s  = hs_s && (sel_rd_s != 5'd0) && !pending_r[sel_rd_s] &&
                !(set_s && (i_issue_rd == sel_rd_s));
    err_nxt_s = err_r | (i_issue_valid & o_rd_busy) | orphan_s;
  end

  assign o_rs1_busy = busy_f(i_rs1_addr, pending_r, we_r, addr_r);
  assign o_rs2_busy = busy_f(i_rs2_addr, pending_r, we_r, addr_r);
  assign o_rd_busy  = busy_f(i_issue_rd, pending_r, we_r, addr_r);

  // Pointer, registered write port, scoreboard and sticky error state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r     <= PW'(N_REQ - 1);
      we_r      <= 1'b0;
      addr_r    <= 5'd0;
      data_r    <= '0;
      pending_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      ptr_r     <= hs_s ? win_s : ptr_r;
      we_r      <= hs_s && (sel_rd_s != 5'd0);
      addr_r    <= hs_s ? sel_rd_s : addr_r;
      data_r    <= hs_s ? sel_data_s : data_r;
      pending_r <= pending_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign o_rf_we      = we_r;
  assign o_rf_rd_addr = addr_r;
  assign o_rf_rd_data = data_r;
  assign o_err        = err_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a behavioural model and a
// write-port scoreboard drained by an independent monitor.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          owner;
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*5-1:0]  req_rd;
  logic [N*XL-1:0] req_data;
  logic            rf_we;
  logic [4:0]      rf_addr;
  logic [XL-1:0]   rf_data;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic            rs1_busy, rs2_busy, rd_busy, err;
  logic            rv [N];
  logic [4:0]      rrd [N];
  logic [31:0]     rdat [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_valid[g]          = rv[g];
    assign req_rd[5*g +: 5]      = rrd[g];
    assign req_data[XL*g +: XL]  = rdat[g];
  end

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rd(req_rd), .i_req_data(req_data),
    .o_rf_we(rf_we), .o_rf_rd_addr(rf_addr), .o_rf_rd_data(rf_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rd_busy(rd_busy),
    .o_err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  bit          mpend [32];
  int          mptr;
  bit          mwe;
  logic [4:0]  maddr;
  logic [31:0] mdata;
  bit          merr;
  int          last_w;
  wr_t         exp_q [$];
  wb_t         wbq [$];
  logic [2:0]  seen_ready;
  logic        seen_rs1, seen_rd_busy, seen_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_arb();
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (mptr + i) % N;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit mbusy(input logic [4:0] a);
    return (a != 5'd0) && mpend[a] && !(mwe && (maddr == a));
  endfunction

  // Monitor: compare the write port against the expected entry after every edge.
  initial begin
    forever begin
      wr_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", 64'(rf_we), 64'(e.we));
        chk("rf_addr", 64'(rf_addr), 64'(e.a));
        chk("rf_data", 64'(rf_data), 64'(e.d));
      end
    end
  end

  task automatic step();
    int w;
    logic [4:0] r;
    bit set, we_n;
    wr_t e;
    @(negedge clk);
    w = model_arb();
    seen_ready = req_ready;
    seen_rs1 = rs1_busy;
    seen_rd_busy = rd_busy;
    seen_err = err;
    chk("ready", 64'(req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    chk("rs1_busy", 64'(rs1_busy), 64'(mbusy(rs1)));
    chk("rs2_busy", 64'(rs2_busy), 64'(mbusy(rs2)));
    chk("rd_busy", 64'(rd_busy), 64'(mbusy(issue_rd)));
    chk("err", 64'(err), 64'(merr));
    set = issue_valid && (issue_rd != 5'd0);
    if (issue_valid && mbusy(issue_rd)) merr = 1'b1;
    r = 5'd0;
    if (w >= 0) begin
      r = rrd[w];
      if (r != 5'd0 && !mpend[r] && !(set && issue_rd == r)) merr = 1'b1;
      mptr = w;
      mdata = rdat[w];
    end
    we_n = (w >= 0) && (r != 5'd0);
    if (mwe) mpend[maddr] = 1'b0;
    if (set) mpend[issue_rd] = 1'b1;
    mwe = we_n;
    if (w >= 0) maddr = r;
    e.we = mwe; e.a = maddr; e.d = mdata;
    exp_q.push_back(e);
    last_w = w;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int k = 0; k < N; k++) rv[k] = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'({rs1_busy, rs2_busy, rd_busy}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    mptr = N - 1; mwe = 1'b0; maddr = 5'd0; mdata = 32'd0; merr = 1'b0; last_w = -1;
    exp_q.delete();
    wbq.delete();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [2:0] rr_exp [8];

  initial begin
    for (int k = 0; k < N; k++) begin rv[k] = 1'b0; rrd[k] = 5'd0; rdat[k] = 32'd0; end
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
    @(posedge clk); #2;
    rs1 = 5'd5; rs2 = 5'd7;
    do_reset();

    // Single write with forwarding
    issue_valid = 1'b1; issue_rd = 5'd5; step();
    issue_valid = 1'b0; rv[0] = 1'b1; rrd[0] = 5'd5; rdat[0] = 32'hDEADBEEF; step();
    chk("t2_ready", 64'(seen_ready), 64'b001);
    rv[0] = 1'b0; rs1 = 5'd5; step();
    chk("t2_fwd", 64'(seen_rs1), 64'd0);
    step();

    // Reset in the middle of a burst
    for (int k = 0; k < N; k++) begin rv[k] = 1'b1; rrd[k] = 5'd0; rdat[k] = 32'(k + 1); end
    step(); step();
    for (int k = 0; k < N; k++) rv[k] = 1'b1;
    do_reset();

    // Round-robin rotation
    for (int k = 0; k < N; k++) begin rv[k] = 1'b1; rrd[k] = 5'd0; end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_grant", 64'(seen_ready), 64'(rr_exp[i]));
    end
    rv[0] = 1'b0; rv[2] = 1'b0; step();
    chk("rr_grant", 64'(seen_ready), 64'(rr_exp[6]));
    rv[0] = 1'b1; rv[2] = 1'b1; step();
    chk("rr_grant", 64'(seen_ready), 64'(rr_exp[7]));

    // rd=0 write is consumed silently
    idle(); rv[1] = 1'b1; rrd[1] = 5'd0; rdat[1] = 32'h1234; step();
    chk("t4_ready", 64'(seen_ready), 64'b010);
    rv[1] = 1'b0; step(); step();

    // Set/clear collision on x7
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    issue_valid = 1'b0; rv[0] = 1'b1; rrd[0] = 5'd7; rdat[0] = 32'hA5A5_0007; step();
    rv[0] = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7; step();
    chk("t5_rd_busy", 64'(seen_rd_busy), 64'd0);
    issue_valid = 1'b0; rs1 = 5'd7; step();
    chk("t5_still_busy", 64'(seen_rs1), 64'd1);
    rv[1] = 1'b1; rrd[1] = 5'd7; rdat[1] = 32'h5A5A_0007; step();
    rv[1] = 1'b0; step(); step();
    chk("t5_cleared", 64'(seen_rs1), 64'd0);

    // Protocol violations
    issue_valid = 1'b1; issue_rd = 5'd3; step(); step();
    issue_valid = 1'b0; step();
    chk("t6_waw_err", 64'(seen_err), 64'd1);
    do_reset();
    rv[2] = 1'b1; rrd[2] = 5'd9; rdat[2] = 32'h9; step();
    rv[2] = 1'b0; step(); step();
    chk("t6_orphan_err", 64'(seen_err), 64'd1);
    do_reset();

    // Randomized legal traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit issued;
      logic [4:0] cand;
      if (cyc == 1500) do_reset();
      issue_valid = 1'b0;
      issued = 1'b0;
      cand = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1 && !mbusy(cand)) begin
        issue_valid = 1'b1; issue_rd = cand; issued = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if (!rv[k] && $urandom_range(0, 3) != 0) begin
          for (int j = 0; j < wbq.size(); j++) begin
            if (wbq[j].owner == k) begin
              rv[k] = 1'b1; rrd[k] = wbq[j].rd; rdat[k] = wbq[j].d;
              break;
            end
          end
        end
      end
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      step();
      if (last_w >= 0) begin
        for (int j = 0; j < wbq.size(); j++) begin
          if (wbq[j].owner == last_w) begin
            wbq.delete(j);
            break;
          end
        end
        rv[last_w] = 1'b0;
      end
      if (issued && cand != 5'd0) begin
        wb_t nb;
        nb.owner = int'($urandom_range(0, N - 1));
        nb.rd = cand;
        nb.d = $urandom;
        wbq.push_back(nb);
      end
    end
    idle();
    step(); step();
    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
